c3_sched: RTL and testbench

C3_SCHED -- requirements
Module: c3_sched

---
 rtl/c3_sched.sv | 190 +++++++++++++++++++
 tb/tb_c3_sched.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c3_sched.sv
// C3 layer scheduler.
// Walks every output pixel of the C3 layer in the order grp -> row -> col -> half.
// Each pixel is issued to the MAC array as two halves, covering input channels
// 0-2 and then 3-5. The scheduler limits how many pixels are in flight, forwards
// the MAC completion strobe to the ReLU/quantise stage, and writes each quantised
// result to output memory in issue order.
//
// Issue handshake: a transfer happens on a rising clk edge where issue_valid and
// issue_ready are both 1. While issue_valid=1 and issue_ready=0, issue_valid and
// all issue_* fields hold their values. issue_valid never depends combinationally
// on issue_ready.
module c3_sched #(
  parameter int OUT_DIM = 10,
  parameter int OCH_GRP = 8,
  parameter int MAX_OUT = 4,
  localparam int OW = $clog2(MAX_OUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          issue_valid,
  input  logic          issue_ready,
  output logic [3:0]    issue_row,
  output logic [3:0]    issue_col,
  output logic [2:0]    issue_grp,
  output logic          issue_half,
  input  logic          mac_done,
  output logic          c3_part_valid,
  input  logic          c3_valid,
  output logic          wr_en,
  output logic [9:0]    wr_addr,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    dbg_state,
  output logic [OW-1:0] dbg_outstanding
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [9:0]    TOTAL    = 10'(OCH_GRP * OUT_DIM * OUT_DIM);
  localparam logic [3:0]    DIM_LAST = 4'(OUT_DIM - 1);
  localparam logic [2:0]    GRP_LAST = 3'(OCH_GRP - 1);
  localparam logic [OW-1:0] MAX_CNT  = OW'(MAX_OUT);

  state_t        state;
  logic [OW-1:0] outstanding;
  logic [9:0]    retire_cnt;

  logic          hs;
  logic          inc_out;
  logic          retire_ok;
  logic          last_issue;
  logic          credit_ok;
  logic [OW-1:0] out_nxt;
  logic [3:0]    nxt_row;
  logic [3:0]    nxt_col;
  logic [2:0]    nxt_grp;
  logic          nxt_half;

  assign dbg_state       = state;
  assign dbg_outstanding = outstanding;

  // Handshake decode, credit arithmetic and next issue coordinates.
  always_comb begin
    hs        = issue_valid && issue_ready;
    inc_out   = hs && !issue_half;
    // A retire with nothing outstanding is a protocol error and is not written.
    retire_ok = c3_valid && (outstanding != '0);

    out_nxt = outstanding;
    if (inc_out && !retire_ok) begin
      out_nxt = outstanding + 1'b1;
    end else if (!inc_out && retire_ok) begin
      out_nxt = outstanding - 1'b1;
    end

    last_issue = (issue_grp == GRP_LAST) && (issue_row == DIM_LAST) &&
                 (issue_col == DIM_LAST) && issue_half;

    nxt_half = issue_half;
    nxt_col  = issue_col;
    nxt_row  = issue_row;
    nxt_grp  = issue_grp;
    if (hs) begin
      nxt_half = ~issue_half;
      if (issue_half) begin
        if (issue_col == DIM_LAST) begin
          nxt_col = '0;
          if (issue_row == DIM_LAST) begin
            nxt_row = '0;
            nxt_grp = (issue_grp == GRP_LAST) ? '0 : issue_grp + 3'd1;
          end else begin
            nxt_row = issue_row + 4'd1;
          end
        end else begin
          nxt_col = issue_col + 4'd1;
        end
      end
    end

    // A second half never needs a credit; a first half needs a free slot.
    credit_ok = nxt_half || (out_nxt < MAX_CNT);
  end

  // Layer FSM plus issue, credit, retire and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      outstanding   <= '0;
      retire_cnt    <= '0;
      issue_valid   <= 1'b0;
      issue_row     <= '0;
      issue_col     <= '0;
      issue_grp     <= '0;
      issue_half    <= 1'b0;
      c3_part_valid <= 1'b0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      c3_part_valid <= mac_done;
      outstanding   <= out_nxt;

      wr_en <= retire_ok;
      if (retire_ok) begin
        wr_addr    <= retire_cnt;
        retire_cnt <= retire_cnt + 10'd1;
      end

      if (c3_valid && (outstanding == '0)) begin
        err <= 1'b1;
      end
      if (mac_done && (state == S_IDLE)) begin
        err <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_ISSUE;
            busy        <= 1'b1;
            retire_cnt  <= '0;
            issue_row   <= '0;
            issue_col   <= '0;
            issue_grp   <= '0;
            issue_half  <= 1'b0;
            issue_valid <= (MAX_CNT != '0);
          end
        end
        S_ISSUE: begin
          issue_row  <= nxt_row;
          issue_col  <= nxt_col;
          issue_grp  <= nxt_grp;
          issue_half <= nxt_half;
          if (hs && last_issue) begin
            issue_valid <= 1'b0;
            state       <= S_DRAIN;
          end else begin
            issue_valid <= credit_ok;
          end
        end
        S_DRAIN: begin
          if (retire_cnt == TOTAL) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_c3_sched.sv
// Directed bench for c3_sched with a small MAC / ReLU responder and a write-address scoreboard.
module tb_c3_sched;

  logic       clk;
  logic       rst;
  logic       start;
  logic       issue_valid;
  logic       issue_ready;
  logic [3:0] issue_row;
  logic [3:0] issue_col;
  logic [2:0] issue_grp;
  logic       issue_half;
  logic       mac_done;
  logic       c3_part_valid;
  logic       c3_valid;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] dbg_state;
  logic [2:0] dbg_outstanding;

  c3_sched dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .issue_valid     (issue_valid),
    .issue_ready     (issue_ready),
    .issue_row       (issue_row),
    .issue_col       (issue_col),
    .issue_grp       (issue_grp),
    .issue_half      (issue_half),
    .mac_done        (mac_done),
    .c3_part_valid   (c3_part_valid),
    .c3_valid        (c3_valid),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .dbg_state       (dbg_state),
    .dbg_outstanding (dbg_outstanding)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counters and scoreboard
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [9:0] exp_q[$];
  logic       mac_q[$];

  // Responder and model state
  int         owed;
  int         model_out;
  int         c3_allow;
  bit         hold_c3;
  bit         c3_force;
  bit         ready_mode;
  bit         start_req;
  logic       exp_wr;
  logic       prev_mac;
  logic       prev_stall;
  logic       prev_vld;
  logic [11:0] saved_tup;
  logic [11:0] first_tup;
  logic [11:0] last_tup;
  logic [11:0] last_ref;
  int         k;
  int         hs_cnt;
  int         h0_cnt;
  int         wr_cnt;
  int         done_cnt;

  function automatic logic [11:0] exp_tup(input int kk);
    int pix;
    pix = kk / 2;
    return {3'(pix / 100), 4'((pix / 10) % 10), 4'(pix % 10), 1'(kk % 2)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: one clock of observation then input drive, all at the falling edge.
  task automatic cycle();
    logic [11:0] tup;
    logic        hs;
    logic        c3_drv;
    @(negedge clk);
    tup = {issue_grp, issue_row, issue_col, issue_half};
    chk("c3_part_valid", 32'(c3_part_valid), 32'(prev_mac));
    chk("wr_en", 32'(wr_en), 32'(exp_wr));
    if (wr_en === 1'b1) begin
      wr_cnt++;
      chk("wr_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("wr_addr", 32'(wr_addr), 32'(exp_q.pop_front()));
    end
    chk("outstanding", 32'(dbg_outstanding), 32'(model_out));
    if (prev_stall) begin
      chk("stall_valid", 32'(issue_valid), 32'(prev_vld));
      chk("stall_fields", 32'(tup), 32'(saved_tup));
    end
    if (issue_valid === 1'b1 && issue_half === 1'b0)
      chk("credit_limit", 32'(model_out < 4), 32'd1);
    if (done === 1'b1) begin
      done_cnt++;
      chk("done_not_busy", 32'(busy), 32'd0);
    end

    issue_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    start = start_req;
    start_req = 1'b0;
    hs = (issue_valid === 1'b1) && issue_ready;
    if (hs) begin
      chk("issue_seq", 32'(tup), 32'(exp_tup(k)));
      if (k == 0) first_tup = tup;
      last_tup = tup;
      if (issue_half == 1'b0) begin
        exp_q.push_back(10'(k / 2));
        h0_cnt++;
      end
      k++;
      hs_cnt++;
    end

    c3_drv = 1'b0;
    if (c3_force) begin
      c3_drv = 1'b1;
      c3_force = 1'b0;
    end else if (owed > 0 && (!hold_c3 || c3_allow > 0)) begin
      c3_drv = 1'b1;
      owed--;
      if (hold_c3) c3_allow--;
    end
    c3_valid = c3_drv;
    mac_done = 1'b0;
    if (mac_q.size() != 0) begin
      mac_done = 1'b1;
      if (mac_q.pop_front() == 1'b1) owed++;
    end
    if (hs) mac_q.push_back(issue_half);

    exp_wr = c3_drv && (model_out > 0);
    model_out = model_out + ((hs && issue_half == 1'b0) ? 1 : 0) - (exp_wr ? 1 : 0);
    prev_mac = mac_done;
    prev_vld = issue_valid;
    prev_stall = (issue_valid === 1'b1) && !issue_ready;
    saved_tup = tup;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    issue_ready = 1'b0;
    mac_done = 1'b0;
    c3_valid = 1'b0;
    mac_q.delete();
    exp_q.delete();
    owed = 0;
    model_out = 0;
    exp_wr = 1'b0;
    prev_mac = 1'b0;
    prev_stall = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_issue_valid", 32'(issue_valid), 32'd0);
    chk("rst_issue_row", 32'(issue_row), 32'd0);
    chk("rst_issue_col", 32'(issue_col), 32'd0);
    chk("rst_issue_grp", 32'(issue_grp), 32'd0);
    chk("rst_issue_half", 32'(issue_half), 32'd0);
    chk("rst_c3_part_valid", 32'(c3_part_valid), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_outstanding", 32'(dbg_outstanding), 32'd0);
    rst = 1'b0;
  endtask

  task automatic begin_layer();
    k = 0;
    hs_cnt = 0;
    h0_cnt = 0;
    wr_cnt = 0;
    done_cnt = 0;
    exp_q.delete();
    start_req = 1'b1;
  endtask

  task automatic run_to_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) cycle();
    chk("done_seen", 32'(done_cnt > 0), 32'd1);
    repeat (4) cycle();
  endtask

  task automatic end_layer_checks();
    chk("layer_handshakes", 32'(hs_cnt), 32'd1600);
    chk("layer_writes", 32'(wr_cnt), 32'd800);
    chk("layer_done_pulses", 32'(done_cnt), 32'd1);
    chk("layer_q_empty", 32'(exp_q.size()), 32'd0);
    chk("layer_busy_low", 32'(busy), 32'd0);
    chk("layer_state_idle", 32'(dbg_state), 32'd0);
    chk("layer_outstanding", 32'(dbg_outstanding), 32'd0);
  endtask

  // Directed sequence
  initial begin
    rst = 1'b1;
    start = 1'b0;
    issue_ready = 1'b0;
    mac_done = 1'b0;
    c3_valid = 1'b0;
    hold_c3 = 1'b0;
    c3_force = 1'b0;
    c3_allow = 0;
    ready_mode = 1'b0;
    start_req = 1'b0;
    prev_vld = 1'b0;
    saved_tup = '0;
    first_tup = '0;
    last_tup = '0;
    k = 0;
    hs_cnt = 0;
    h0_cnt = 0;
    wr_cnt = 0;
    done_cnt = 0;
    do_reset();

    // Idle until started, then a full layer with prompt responses.
    repeat (5) cycle();
    chk("idle_no_issue", 32'(issue_valid), 32'd0);
    chk("idle_not_busy", 32'(busy), 32'd0);
    begin_layer();
    repeat (3) cycle();
    chk("layer_busy", 32'(busy), 32'd1);
    chk("layer_state_issue", 32'(dbg_state), 32'd1);
    run_to_done(5000);
    end_layer_checks();
    last_ref = {3'd7, 4'd9, 4'd9, 1'b1};
    chk("first_issue", 32'(first_tup), 32'd0);
    chk("last_issue", 32'(last_tup), 32'(last_ref));

    // Credit limit: hold retires until issue stalls with four pixels outstanding.
    hold_c3 = 1'b1;
    begin_layer();
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (hs_cnt > 0 && issue_valid === 1'b0) break;
    end
    chk("credit_stall", 32'(issue_valid), 32'd0);
    chk("credit_h0_count", 32'(h0_cnt), 32'd4);
    chk("credit_next_half", 32'(issue_half), 32'd0);
    chk("credit_outstanding", 32'(dbg_outstanding), 32'd4);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("credit_hold", 32'(issue_valid), 32'd0);
    end
    c3_allow = 1;
    cycle();
    c3_allow = 1;
    cycle();
    chk("credit_reopen", 32'(issue_valid), 32'd1);
    chk("credit_reopen_half", 32'(issue_half), 32'd0);
    cycle();
    chk("simul_hs_retire", 32'(dbg_outstanding), 32'd3);
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (issue_valid === 1'b0) break;
    end
    chk("credit_restall", 32'(issue_valid), 32'd0);
    chk("credit_restall_out", 32'(dbg_outstanding), 32'd4);
    chk("credit_no_err", 32'(err), 32'd0);

    // Release retires and run the rest of the layer with random ready.
    hold_c3 = 1'b0;
    ready_mode = 1'b1;
    run_to_done(10000);
    end_layer_checks();
    chk("random_no_err", 32'(err), 32'd0);

    // Reset mid-layer abandons in-flight work.
    ready_mode = 1'b0;
    begin_layer();
    for (int i = 0; i < 2000 && hs_cnt < 300; i++) cycle();
    chk("mid_hs_reached", 32'(hs_cnt >= 300), 32'd1);
    do_reset();
    wr_cnt = 0;
    repeat (50) cycle();
    chk("post_rst_no_wr", 32'(wr_cnt), 32'd0);
    chk("post_rst_idle", 32'(busy), 32'd0);
    chk("post_rst_no_issue", 32'(issue_valid), 32'd0);

    // Restart from address 0; stray retire sets err; start while busy is ignored.
    begin_layer();
    cycle();
    c3_force = 1'b1;
    cycle();
    cycle();
    chk("err_set", 32'(err), 32'd1);
    for (int i = 0; i < 1000 && hs_cnt < 100; i++) cycle();
    start_req = 1'b1;
    run_to_done(5000);
    end_layer_checks();
    chk("err_sticky", 32'(err), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
